// File: rtl/sccb_config_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer_pkg
// Shared definitions for the OV2640 bring-up sequencer and its config ROM:
// ROM entry layout, opcode encoding and sequencer state encoding.
// -----------------------------------------------------------------------------
package sccb_config_sequencer_pkg;

    localparam int unsigned ROM_ENTRY_W = 18;
    localparam int unsigned REG_W       = 8;

    // Opcode field of a ROM entry; 2'b11 is reserved and behaves like END.
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_DELAY = 2'b01,
        OP_END   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // One ROM word: {op[17:16], reg[15:8], val[7:0]}.
    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rega;
        logic [REG_W-1:0] val;
    } rom_entry_t;

    typedef enum logic [2:0] {
        ST_WAIT_START = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_SEND       = 3'd3,
        ST_DELAY      = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    // Packs one ROM word from its fields.
    function automatic logic [ROM_ENTRY_W-1:0] mk_entry(input op_e op,
                                                        input logic [REG_W-1:0] rega,
                                                        input logic [REG_W-1:0] val);
        mk_entry = {op, rega, val};
    endfunction

endpackage

// File: rtl/sccb_config_sequencer_if.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer_if
// Pair handshake between the config sequencer and the SCCB write master.
//   send  : pair valid, held until taken
//   rega  : register address
//   value : register data
//   taken : one-cycle pulse from the SCCB master, pair latched
// Modports: master = sequencer side, slave = SCCB write master side.
// -----------------------------------------------------------------------------
interface sccb_config_sequencer_if;
    import sccb_config_sequencer_pkg::*;

    logic             send;
    logic [REG_W-1:0] rega;
    logic [REG_W-1:0] value;
    logic             taken;

    modport master (output send, output rega, output value, input taken);
    modport slave  (input send, input rega, input value, output taken);

endinterface

// File: rtl/sccb_config_sequencer_rom.sv
// -----------------------------------------------------------------------------
// ov2640_config_rom
// Case-based synchronous ROM holding the OV2640 register table.
// Ports:
//   clk_i  : clock
//   addr_i : entry address (8 bits)
//   data_o : 18-bit entry, registered (1-cycle read latency)
// Unlisted addresses read as END so a short table terminates cleanly.
// -----------------------------------------------------------------------------
module ov2640_config_rom
    import sccb_config_sequencer_pkg::*;
(
    input  logic                   clk_i,
    input  logic [7:0]             addr_i,
    output logic [ROM_ENTRY_W-1:0] data_o
);

    // Registered table lookup.
    always_ff @(posedge clk_i) begin
        case (addr_i)
            8'd0:    data_o <= mk_entry(OP_WRITE, 8'hFF, 8'h01); // bank select: sensor
            8'd1:    data_o <= mk_entry(OP_WRITE, 8'h12, 8'h80); // COM7 soft reset
            8'd2:    data_o <= mk_entry(OP_DELAY, 8'h00, 8'h05); // let the reset settle
            8'd3:    data_o <= mk_entry(OP_WRITE, 8'hFF, 8'h00); // bank select: DSP
            8'd4:    data_o <= mk_entry(OP_WRITE, 8'h2C, 8'hFF);
            8'd5:    data_o <= mk_entry(OP_WRITE, 8'h2E, 8'hDF);
            8'd6:    data_o <= mk_entry(OP_WRITE, 8'hFF, 8'h01); // bank select: sensor
            8'd7:    data_o <= mk_entry(OP_WRITE, 8'h3C, 8'h32);
            8'd8:    data_o <= mk_entry(OP_WRITE, 8'h11, 8'h00); // CLKRC
            8'd9:    data_o <= mk_entry(OP_WRITE, 8'h09, 8'h02); // COM2 drive
            default: data_o <= mk_entry(OP_END,   8'h00, 8'h00);
        endcase
    end

endmodule

// File: rtl/sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_config_sequencer
// Walks an external synchronous config ROM and feeds register/value pairs to
// the SCCB write master, executing DELAY and END opcodes along the way.
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous reset, active-high (beats restart_i)
//   restart_i  : single-cycle pulse, reruns the sequence from address 0
//   bus        : pair handshake (send/rega/value out, taken in)
//   done_o     : sequence complete, sticky until restart/reset
//   rom_addr_o : ROM address
//   rom_data_i : ROM entry, valid one cycle after rom_addr_o
// -----------------------------------------------------------------------------
module sccb_config_sequencer
    import sccb_config_sequencer_pkg::*;
#(
    parameter int unsigned ROM_AW            = 8,
    parameter int unsigned STARTUP_CYCLES    = 1_000_000,
    parameter int unsigned DELAY_UNIT_CYCLES = 50_000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     restart_i,
    sccb_config_sequencer_if.master  bus,
    output logic                     done_o,
    output logic [ROM_AW-1:0]        rom_addr_o,
    input  logic [ROM_ENTRY_W-1:0]   rom_data_i
);

    localparam int unsigned DELAY_MAX = 255 * DELAY_UNIT_CYCLES;
    localparam int unsigned CNT_MAX   = (STARTUP_CYCLES > DELAY_MAX) ? STARTUP_CYCLES : DELAY_MAX;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [ROM_AW-1:0] LAST_ADDR = {ROM_AW{1'b1}};

    state_e              state_q;
    logic [CNT_W-1:0]    counter_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic                send_q;
    logic [REG_W-1:0]    rega_q;
    logic [REG_W-1:0]    value_q;
    logic                done_q;

    rom_entry_t          entry_s;
    logic [CNT_W-1:0]    delay_load_s;
    logic                at_last_s;

    assign entry_s = rom_entry_t'(rom_data_i);

    // Delay occupies exactly val*DELAY_UNIT_CYCLES cycles in DELAY, so load one less.
    assign delay_load_s = CNT_W'(entry_s.val) * CNT_W'(DELAY_UNIT_CYCLES) - CNT_W'(1);

    // Finishing the last addressable entry ends the sequence instead of wrapping.
    assign at_last_s = (rom_addr_q == LAST_ADDR);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_WAIT_START;
            counter_q  <= '0;
            rom_addr_q <= '0;
            send_q     <= 1'b0;
            rega_q     <= '0;
            value_q    <= '0;
            done_q     <= 1'b0;
        end else if (restart_i) begin
            // Restart beats a coincident taken: the address is not advanced.
            state_q    <= ST_WAIT_START;
            counter_q  <= '0;
            rom_addr_q <= '0;
            send_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_START: begin
                    if (counter_q == CNT_W'(STARTUP_CYCLES - 32'd1)) begin
                        counter_q <= '0;
                        state_q   <= ST_FETCH;
                    end else begin
                        counter_q <= counter_q + CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    // rom_addr has been stable for the ROM's one-cycle read.
                    state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (entry_s.op)
                        OP_WRITE: begin
                            rega_q  <= entry_s.rega;
                            value_q <= entry_s.val;
                            send_q  <= 1'b1;
                            state_q <= ST_SEND;
                        end
                        OP_DELAY: begin
                            if (entry_s.val == 8'd0) begin
                                if (at_last_s) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    rom_addr_q <= rom_addr_q + ROM_AW'(1);
                                    state_q    <= ST_FETCH;
                                end
                            end else begin
                                counter_q <= delay_load_s;
                                state_q   <= ST_DELAY;
                            end
                        end
                        default: begin
                            // END and the reserved opcode both terminate.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (bus.taken) begin
                        send_q <= 1'b0;
                        if (at_last_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= ST_FETCH;
                        end
                    end else begin
                        send_q <= 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (counter_q == '0) begin
                        if (at_last_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= ST_FETCH;
                        end
                    end else begin
                        counter_q <= counter_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    send_q <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover by rerunning from the start.
                    state_q    <= ST_WAIT_START;
                    counter_q  <= '0;
                    rom_addr_q <= '0;
                    send_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.send   = send_q;
    assign bus.rega   = rega_q;
    assign bus.value  = value_q;
    assign done_o     = done_q;
    assign rom_addr_o = rom_addr_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_config_sequencer
// Directed bench: two sequencer instances on behavioural test ROMs
// (ROM_AW=8 and ROM_AW=2) plus a spot check of the OV2640 table ROM.
// -----------------------------------------------------------------------------
module tb_sccb_config_sequencer;
    import sccb_config_sequencer_pkg::*;

    logic clk;
    logic rst1, rst2, restart1, restart2;
    logic done1, done2;
    logic [7:0]  rom1_addr;
    logic [1:0]  rom2_addr;
    logic [17:0] rom1_data, rom2_data;
    logic [17:0] rom1_mem [0:255];
    logic [17:0] rom2_mem [0:3];
    logic [7:0]  rom3_addr;
    logic [17:0] rom3_data;

    int n_vec = 0;
    int n_err = 0;

    sccb_config_sequencer_if bus1();
    sccb_config_sequencer_if bus2();

    sccb_config_sequencer #(.ROM_AW(8), .STARTUP_CYCLES(10), .DELAY_UNIT_CYCLES(4)) dut1 (
        .clk_i(clk), .rst_i(rst1), .restart_i(restart1), .bus(bus1),
        .done_o(done1), .rom_addr_o(rom1_addr), .rom_data_i(rom1_data));

    sccb_config_sequencer #(.ROM_AW(2), .STARTUP_CYCLES(10), .DELAY_UNIT_CYCLES(4)) dut2 (
        .clk_i(clk), .rst_i(rst2), .restart_i(restart2), .bus(bus2),
        .done_o(done2), .rom_addr_o(rom2_addr), .rom_data_i(rom2_data));

    ov2640_config_rom u_rom (.clk_i(clk), .addr_i(rom3_addr), .data_o(rom3_data));

    always #5 clk = ~clk;

    // Behavioural test ROMs with one-cycle read latency.
    always @(posedge clk) begin
        rom1_data <= rom1_mem[rom1_addr];
        rom2_data <= rom2_mem[rom2_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges until send rises on the chosen instance, bounded by max_cyc.
    task automatic wait_send(input int which, input int max_cyc, output int n);
        logic s;
        n = 0;
        do begin
            step();
            n++;
            s = (which == 1) ? bus1.send : bus2.send;
        end while (!s && n < max_cyc);
    endtask

    task automatic pulse_taken(input int which);
        if (which == 1) bus1.taken = 1'b1; else bus2.taken = 1'b1;
        step();
        bus1.taken = 1'b0;
        bus2.taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic ok;
        clk = 1'b0;
        rst1 = 1'b1; rst2 = 1'b1; restart1 = 1'b0; restart2 = 1'b0;
        bus1.taken = 1'b0; bus2.taken = 1'b0;
        rom3_addr = 8'd0;
        for (int i = 0; i < 256; i++) rom1_mem[i] = {2'b10, 8'h00, 8'h00};
        rom1_mem[0] = {2'b00, 8'hFF, 8'h01};
        rom1_mem[1] = {2'b00, 8'h12, 8'h80};
        rom1_mem[2] = {2'b01, 8'h00, 8'h03};
        rom1_mem[3] = {2'b00, 8'h11, 8'h00};
        rom1_mem[4] = {2'b01, 8'h00, 8'h00};
        rom1_mem[5] = {2'b00, 8'h09, 8'h02};
        rom1_mem[6] = {2'b10, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) rom2_mem[i] = {2'b00, 8'h10 + 8'(i), 8'hA0 + 8'(i)};

        repeat (3) step();
        check_val("rst_send",  32'(bus1.send),  32'h0);
        check_val("rst_rega",  32'(bus1.rega),  32'h0);
        check_val("rst_value", 32'(bus1.value), 32'h0);
        check_val("rst_done",  32'(done1),      32'h0);
        check_val("rst_addr",  32'(rom1_addr),  32'h0);

        // Startup wait: first send STARTUP_CYCLES+2 edges after release.
        rst1 = 1'b0;
        wait_send(1, 40, n);
        check_val("startup_lat", 32'(n), 32'd12);
        check_val("p0_rega",  32'(bus1.rega),  32'hFF);
        check_val("p0_value", 32'(bus1.value), 32'h01);

        // Handshake stall.
        ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (!(bus1.send === 1'b1 && bus1.rega === 8'hFF && bus1.value === 8'h01)) ok = 1'b0;
        end
        check_val("stall_stable", 32'(ok), 32'h1);
        pulse_taken(1);
        check_val("taken_send_fall", 32'(bus1.send), 32'h0);
        check_val("taken_addr",      32'(rom1_addr), 32'h1);
        step();
        check_val("gap_send", 32'(bus1.send), 32'h0);
        step();
        check_val("p1_send",  32'(bus1.send),  32'h1);
        check_val("p1_rega",  32'(bus1.rega),  32'h12);
        check_val("p1_value", 32'(bus1.value), 32'h80);

        // DELAY 3 x 4 cycles: 12 in DELAY plus fetch/decode of both entries.
        pulse_taken(1);
        wait_send(1, 100, n);
        check_val("delay3_lat", 32'(n), 32'd16);
        check_val("p3_rega",    32'(bus1.rega), 32'h11);

        // DELAY 0 advances without waiting.
        pulse_taken(1);
        wait_send(1, 100, n);
        check_val("delay0_lat", 32'(n), 32'd4);
        check_val("p5_rega",  32'(bus1.rega),  32'h09);
        check_val("p5_value", 32'(bus1.value), 32'h02);
        check_val("p5_addr",  32'(rom1_addr),  32'h5);

        // Restart coincident with taken at address 5.
        restart1 = 1'b1; bus1.taken = 1'b1;
        step();
        restart1 = 1'b0; bus1.taken = 1'b0;
        check_val("rs_send", 32'(bus1.send), 32'h0);
        check_val("rs_done", 32'(done1),     32'h0);
        check_val("rs_addr", 32'(rom1_addr), 32'h0);
        wait_send(1, 40, n);
        check_val("rs_lat",  32'(n),         32'd12);
        check_val("rs_rega", 32'(bus1.rega), 32'hFF);
        check_val("rs_addr_hold", 32'(rom1_addr), 32'h0);

        // Second pass through to END.
        pulse_taken(1); wait_send(1, 100, n);
        check_val("pass2_p1", 32'(n), 32'd2);
        pulse_taken(1); wait_send(1, 100, n);
        check_val("pass2_p3", 32'(n), 32'd16);
        pulse_taken(1); wait_send(1, 100, n);
        check_val("pass2_p5", 32'(n), 32'd4);
        pulse_taken(1);
        n = 0;
        while (done1 !== 1'b1 && n < 20) begin step(); n++; end
        check_val("end_lat",  32'(n),         32'd2);
        check_val("end_send", 32'(bus1.send), 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus1.taken = ((i % 100) == 50);
            step();
            if (!(done1 === 1'b1 && bus1.send === 1'b0 && rom1_addr === 8'd6)) ok = 1'b0;
        end
        bus1.taken = 1'b0;
        check_val("done_sticky", 32'(ok), 32'h1);
        restart1 = 1'b1;
        step();
        restart1 = 1'b0;
        check_val("done_clear", 32'(done1), 32'h0);

        // Full ROM, ROM_AW=2: four pairs then done, no wrap.
        rst2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_send(2, 40, n);
            check_val("full_send",  32'(bus2.send),  32'h1);
            check_val("full_rega",  32'(bus2.rega),  32'h10 + 32'(i));
            check_val("full_value", 32'(bus2.value), 32'hA0 + 32'(i));
            pulse_taken(2);
        end
        check_val("full_done", 32'(done2), 32'h1);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!(bus2.send === 1'b0 && done2 === 1'b1 && rom2_addr === 2'd3)) ok = 1'b0;
        end
        check_val("full_no_wrap", 32'(ok), 32'h1);

        // OV2640 table ROM spot checks.
        rom3_addr = 8'd0; step();
        check_val("rom_0",   32'(rom3_data), 32'h0FF01);
        rom3_addr = 8'd2; step();
        check_val("rom_2",   32'(rom3_data), 32'h10005);
        rom3_addr = 8'd200; step();
        check_val("rom_200", 32'(rom3_data), 32'h20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
